// File: rtl/latch_ex_m_hs.sv
// EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Sits between the ALU stage and the data-memory stage.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   flush                squash held entries and any same-cycle input
//   in_valid / in_ready  EX-side handshake (in_ready is a flop)
//   mem_to_reg .. dst    incoming EX payload fields
//   out_valid/out_ready  MEM-side handshake for the head entry
//   *_reg                head entry fields (control bits gated by out_valid)
//   branch_taken         valid head with branch and zero both set
//   stall_cnt            saturating count of cycles with out_valid & ~out_ready
module latch_ex_m_hs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 7,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              branch,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [PC_W-1:0]   pc_branch,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] data2,
  input  logic [REG_W-1:0]  dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_to_reg_reg,
  output logic              reg_write_reg,
  output logic              branch_reg,
  output logic              mem_write_reg,
  output logic              mem_read_reg,
  output logic [PC_W-1:0]   pc_branch_reg,
  output logic              zero_reg,
  output logic [DATA_W-1:0] alu_result_reg,
  output logic [DATA_W-1:0] data2_reg,
  output logic [REG_W-1:0]  dst_reg,
  output logic              branch_taken,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic              branch;
    logic              mem_write;
    logic              mem_read;
    logic              zero;
    logic [PC_W-1:0]   pc_branch;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] data2;
    logic [REG_W-1:0]  dst;
  } payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  payload_t in_pay_c;
  logic     accept_c;
  logic     xfer_c;
  logic     valid_d;
  logic     ready_d;

  // Pack the incoming fields into one payload word.
  always_comb begin
    in_pay_c = '{
      mem_to_reg: mem_to_reg,
      reg_write:  reg_write,
      branch:     branch,
      mem_write:  mem_write,
      mem_read:   mem_read,
      zero:       zero,
      pc_branch:  pc_branch,
      alu_result: alu_result,
      data2:      data2,
      dst:        dst
    };
  end

  assign accept_c = in_valid & in_ready;
  assign xfer_c   = out_valid & out_ready;

  // Next-state and payload steering; flush drops both entries and the input.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    valid_d = 1'b0;
    ready_d = 1'b1;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept_c) begin
            state_d = S_ONE;
            main_d  = in_pay_c;
          end
        end
        S_ONE: begin
          if (accept_c && xfer_c) begin
            main_d = in_pay_c;
          end else if (accept_c) begin
            state_d = S_FULL;
            skid_d  = in_pay_c;
          end else if (xfer_c) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (xfer_c) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    valid_d = (state_d != S_EMPTY);
    ready_d = (state_d != S_FULL);
  end

  // State, payload and handshake flops; control outputs are gated one cycle early
  // from the next-state so they are flop outputs yet never assert on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_EMPTY;
      main_q         <= '0;
      skid_q         <= '0;
      out_valid      <= 1'b0;
      in_ready       <= 1'b1;
      mem_to_reg_reg <= 1'b0;
      reg_write_reg  <= 1'b0;
      branch_reg     <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      branch_taken   <= 1'b0;
    end else begin
      state_q        <= state_d;
      main_q         <= main_d;
      skid_q         <= skid_d;
      out_valid      <= valid_d;
      in_ready       <= ready_d;
      mem_to_reg_reg <= valid_d & main_d.mem_to_reg;
      reg_write_reg  <= valid_d & main_d.reg_write;
      branch_reg     <= valid_d & main_d.branch;
      mem_write_reg  <= valid_d & main_d.mem_write;
      mem_read_reg   <= valid_d & main_d.mem_read;
      branch_taken   <= valid_d & main_d.branch & main_d.zero;
    end
  end

  // Data outputs come straight from the head register and hold while invalid.
  assign pc_branch_reg  = main_q.pc_branch;
  assign zero_reg       = main_q.zero;
  assign alu_result_reg = main_q.alu_result;
  assign data2_reg      = main_q.data2;
  assign dst_reg        = main_q.dst;

  // Saturating back-pressure counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_latch_ex_m_hs.sv
// Self-checking bench for latch_ex_m_hs: queue-based reference model plus
// directed literal checks, followed by randomized traffic.
module tb_latch_ex_m_hs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned PAY_W  = 6 + PC_W + 2 * DATA_W + REG_W;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic mem_to_reg, reg_write, branch, mem_write, mem_read, zero;
  logic [PC_W-1:0]   pc_branch;
  logic [DATA_W-1:0] alu_result, data2;
  logic [REG_W-1:0]  dst;

  logic              in_ready, out_valid;
  logic              mem_to_reg_reg, reg_write_reg, branch_reg, mem_write_reg, mem_read_reg;
  logic [PC_W-1:0]   pc_branch_reg;
  logic              zero_reg, branch_taken;
  logic [DATA_W-1:0] alu_result_reg, data2_reg;
  logic [REG_W-1:0]  dst_reg;
  logic [15:0]       stall_cnt;

  logic              d3_in_ready, d3_out_valid;
  logic              d3_m2r, d3_rw, d3_br, d3_mw, d3_mr;
  logic [PC_W-1:0]   d3_pc;
  logic              d3_zero, d3_bt;
  logic [DATA_W-1:0] d3_alu, d3_d2;
  logic [REG_W-1:0]  d3_dst;
  logic [2:0]        d3_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  latch_ex_m_hs u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
    .mem_write(mem_write), .mem_read(mem_read), .pc_branch(pc_branch), .zero(zero),
    .alu_result(alu_result), .data2(data2), .dst(dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_to_reg_reg(mem_to_reg_reg), .reg_write_reg(reg_write_reg), .branch_reg(branch_reg),
    .mem_write_reg(mem_write_reg), .mem_read_reg(mem_read_reg), .pc_branch_reg(pc_branch_reg),
    .zero_reg(zero_reg), .alu_result_reg(alu_result_reg), .data2_reg(data2_reg),
    .dst_reg(dst_reg), .branch_taken(branch_taken), .stall_cnt(stall_cnt)
  );

  latch_ex_m_hs #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d3_in_ready),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
    .mem_write(mem_write), .mem_read(mem_read), .pc_branch(pc_branch), .zero(zero),
    .alu_result(alu_result), .data2(data2), .dst(dst),
    .out_valid(d3_out_valid), .out_ready(out_ready),
    .mem_to_reg_reg(d3_m2r), .reg_write_reg(d3_rw), .branch_reg(d3_br),
    .mem_write_reg(d3_mw), .mem_read_reg(d3_mr), .pc_branch_reg(d3_pc),
    .zero_reg(d3_zero), .alu_result_reg(d3_alu), .data2_reg(d3_d2),
    .dst_reg(d3_dst), .branch_taken(d3_bt), .stall_cnt(d3_stall_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two payloads, plus the last head shown.
  logic [PAY_W-1:0] q[$];
  logic [PAY_W-1:0] head = '0;
  int unsigned      m_cnt = 0;
  int unsigned      m_cnt3 = 0;
  bit               model_ok = 1'b0;

  always @(posedge clk) begin
    bit m_ov, m_ir;
    if (rst) begin
      q.delete();
      head     = '0;
      m_cnt    = 0;
      m_cnt3   = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_ov = (q.size() > 0);
      m_ir = (q.size() < 2);
      if (m_ov && !out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (m_ov && out_ready) void'(q.pop_front());
        if (in_valid && m_ir)
          q.push_back({mem_to_reg, reg_write, branch, mem_write, mem_read, zero,
                       pc_branch, alu_result, data2, dst});
      end
      if (q.size() > 0) head = q[0];
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    bit ov;
    if (model_ok) begin
      ov = (q.size() > 0);
      check("out_valid", 128'(out_valid), 128'(ov));
      check("in_ready", 128'(in_ready), 128'(q.size() < 2));
      check("ctrl", 128'({mem_to_reg_reg, reg_write_reg, branch_reg, mem_write_reg, mem_read_reg}),
            ov ? 128'(head[PAY_W-1 -: 5]) : 128'(0));
      check("data", 128'({zero_reg, pc_branch_reg, alu_result_reg, data2_reg, dst_reg}),
            128'(head[PAY_W-6:0]));
      check("branch_taken", 128'(branch_taken), 128'(ov & head[PAY_W-3] & head[PAY_W-6]));
      check("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
      check("stall_cnt3", 128'(d3_stall_cnt), 128'(m_cnt3));
      check("d3_out_valid", 128'(d3_out_valid), 128'(ov));
    end
  end

  task automatic set_pay(input logic m2r, input logic rw, input logic br, input logic mw,
                         input logic mr, input logic z, input logic [PC_W-1:0] pc,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] d2,
                         input logic [REG_W-1:0] rd);
    mem_to_reg = m2r; reg_write = rw; branch = br; mem_write = mw; mem_read = mr;
    zero = z; pc_branch = pc; alu_result = alu; data2 = d2; dst = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_pay(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);

    // Reset state
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    check("rst_regs", 128'({reg_write_reg, alu_result_reg, dst_reg, pc_branch_reg}), 128'(0));

    // Single payload, pass-through
    out_ready = 1'b1;
    set_pay(0, 1, 0, 0, 0, 0, '0, 32'h0000_00A5, 32'h0, 5'd3);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_valid", 128'(out_valid), 128'(1));
    check("t2_alu", 128'(alu_result_reg), 128'(32'hA5));
    check("t2_dst", 128'(dst_reg), 128'(3));
    check("t2_rw", 128'(reg_write_reg), 128'(1));
    @(negedge clk);
    check("t2_bubble_valid", 128'(out_valid), 128'(0));
    check("t2_bubble_rw", 128'(reg_write_reg), 128'(0));

    // Back-pressure fills the skid buffer
    out_ready = 1'b0;
    set_pay(0, 1, 0, 0, 0, 0, '0, 32'h11, 32'h0, 5'd1);
    in_valid = 1'b1;
    step();
    alu_result = 32'h22;
    step();
    alu_result = 32'h33;
    @(negedge clk);
    check("t3_full_ready", 128'(in_ready), 128'(0));
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_stall", 128'(stall_cnt), 128'(2));
    check("t3_head0", 128'(alu_result_reg), 128'(32'h11));
    @(negedge clk);
    check("t3_head1", 128'(alu_result_reg), 128'(32'h22));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_head2", 128'(alu_result_reg), 128'(32'h33));
    @(negedge clk);
    check("t3_drained", 128'(out_valid), 128'(0));

    // Flush while full, with a same-cycle input
    out_ready = 1'b0;
    set_pay(0, 0, 0, 1, 0, 0, '0, 32'h44, 32'h0, 5'd4);
    in_valid = 1'b1;
    step();
    alu_result = 32'h55;
    step();
    alu_result = 32'h66;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_valid", 128'(out_valid), 128'(0));
    check("t4_ready", 128'(in_ready), 128'(1));
    check("t4_mw", 128'(mem_write_reg), 128'(0));
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_no_ghost", 128'(out_valid), 128'(0));

    // Branch-taken qualifier
    set_pay(0, 0, 1, 0, 0, 1, 7'h2C, 32'h1, 32'h0, 5'd0);
    in_valid = 1'b1;
    step();
    set_pay(0, 0, 1, 0, 0, 0, 7'h15, 32'h2, 32'h0, 5'd0);
    @(negedge clk);
    check("t5_taken", 128'(branch_taken), 128'(1));
    check("t5_pc", 128'(pc_branch_reg), 128'(7'h2C));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_not_taken", 128'(branch_taken), 128'(0));

    // Stall counter saturation on the narrow instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    set_pay(0, 0, 0, 0, 0, 0, '0, 32'h77, 32'h0, 5'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t6_sat", 128'(d3_stall_cnt), 128'(7));
    check("t6_wide", 128'(stall_cnt), 128'(10));
    @(negedge clk);
    check("t6_sat_hold", 128'(d3_stall_cnt), 128'(7));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst", 128'(d3_stall_cnt), 128'(0));

    // Randomized traffic; the source holds its payload while stalled
    for (int i = 0; i < 4000; i++) begin
      step();
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if ((i % 600) < 50) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 3) != 0);
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        set_pay(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), PC_W'($urandom), $urandom, $urandom, REG_W'($urandom));
      end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_ex_m_hs.md
Name: latch_ex_m_hs

Overview:
- Parametrised EX/MEM pipeline register, successor to the fixed-width unconditional stage latch.
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered.
- Adds a synchronous flush for branch/exception squash, bubble gating of the control bits, a branch-taken qualifier and a saturating stall counter.
- Sits between the ALU stage and the data-memory stage.

Parameters:
DATA_W, 32, width of alu_result and data2
PC_W, 7, width of pc_branch
REG_W, 5, width of dst register address
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous squash of all held and incoming entries
in_valid  in  1  EX stage presents a payload
in_ready  out  1  stage can accept; registered
mem_to_reg, reg_write, branch, mem_write, mem_read  in  1 each  control bits
pc_branch  in  PC_W  branch target
zero  in  1  ALU zero flag
alu_result  in  DATA_W  ALU result
data2  in  DATA_W  store data
dst  in  REG_W  destination register
out_valid  out  1  head entry is valid
out_ready  in  1  MEM stage consumes head entry
mem_to_reg_reg, reg_write_reg, branch_reg, mem_write_reg, mem_read_reg  out  1 each  head control bits, gated by out_valid
pc_branch_reg  out  PC_W  head branch target
zero_reg  out  1  head zero flag
alu_result_reg  out  DATA_W  head ALU result
data2_reg  out  DATA_W  head store data
dst_reg  out  REG_W  head destination
branch_taken  out  1  out_valid & branch_reg & zero_reg
stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready, saturating

Behaviour:
- Payload = all input fields packed, width 6+PC_W+2*DATA_W+REG_W. It is held in two registers: main (head) and skid.
- accept = in_valid & in_ready.
- xfer = out_valid & out_ready.
- State machine:
  - EMPTY (no entries): out_valid=0, in_ready=1.
  - ONE (main valid): out_valid=1, in_ready=1.
  - FULL (main and skid valid): out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: accept -> ONE, main<=in.
  - ONE: accept&xfer -> ONE, main<=in. accept&~xfer -> FULL, skid<=in. ~accept&xfer -> EMPTY. Otherwise hold.
  - FULL: xfer -> ONE, main<=skid. Otherwise hold; no accept is possible.
- Latency: an accepted payload appears on the outputs the next cycle when the stage was EMPTY, or was ONE with a same-cycle xfer. Ordering is strictly FIFO. Throughput is 1 per cycle when out_ready=1.
- Priority: rst > flush > normal operation.
- rst: state=EMPTY, in_ready=1, out_valid=0, all payload registers=0, stall_cnt=0, branch_taken=0.
- flush: state=EMPTY next cycle. Both entries and any same-cycle input are discarded, even if accept is true. Payload registers hold their value. stall_cnt is unaffected. A flush in the same cycle as an xfer still counts that xfer as consumed by MEM.
- Control outputs and branch_taken are forced to 0 when out_valid=0, so a bubble never writes memory or the register file. Data outputs hold their last value while invalid.
- stall_cnt increments when out_valid&~out_ready, saturates at 2^CNT_W-1, and is cleared only by rst.
- in_ready is a flop output (~FULL next-state). There is no combinational path from out_ready to in_ready.
- If the EX stage drives in_valid while in_ready=0, the input is ignored. The source must hold its payload.

Test Plan:
1. rst=1 for 2 cycles, then 0 -> out_valid=0, in_ready=1, stall_cnt=0, every *_reg output=0.
2. out_ready=1; one payload (alu_result=0x0000_00A5, dst=3, reg_write=1) -> next cycle out_valid=1, alu_result_reg=0xA5, dst_reg=3, reg_write_reg=1. The cycle after that, out_valid=0 and reg_write_reg=0.
3. out_ready=0; send A=0x11 then B=0x22 -> after B, in_ready=0 and C=0x33 is not accepted. Raise out_ready -> head sequence 0x11, 0x22, then 0x33 after resend. No loss or duplication. stall_cnt=2 at the cycle out_ready rises.
4. FULL state with in_valid=1 and flush=1 -> next cycle out_valid=0, in_ready=1, mem_write_reg=0. The flushed-cycle input never appears on the outputs.
5. branch=1, zero=1, pc_branch=0x2C; then a second payload with branch=1, zero=0 -> branch_taken=1 with pc_branch_reg=0x2C, then branch_taken=0.
6. CNT_W=3, out_valid held with out_ready=0 for 10 cycles -> stall_cnt reads 7 and stays 7. rst -> 0.
